aes_cmd_sequencer: RTL
======================

# aes_cmd_sequencer

Command sequencer between the UART receive path and the AES-128 encryption core. It takes complete 18-byte UART frames, validates the framing bytes, loads key and plaintext registers, and starts the cipher. It waits for completion, then builds the 18-byte response frame and hands it to the UART transmit path. It replaces the ad-hoc decoder in the top level with a proper FSM that has timeout and error accounting.

## Interface
- FRAME_BYTES, 18, bytes per UART frame (command + 16 payload + command trailer)
- DBITS, 8, bits per byte
- TIMEOUT_CYCLES, 64, max cycles in WAIT_DONE before abort

- clk  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- frame_in  in  FRAME_BYTES*DBITS  received frame; byte 0 (command) = [143:136], payload = [135:8], trailer = [7:0]
- frame_valid  in  1  one-cycle strobe, frame_in valid this cycle
- tx_ready  in  1  UART transmitter idle, can accept a frame
- aes_done  in  1  cipher core completion strobe
- aes_text_out  in  128  cipher core result
- aes_key  out  128  key register to core
- aes_text_in  out  128  plaintext register to core
- aes_ld  out  1  one-cycle start strobe to core
- tx_frame  out  FRAME_BYTES*DBITS  response frame to transmitter
- tx_send  out  1  one-cycle transmit trigger
- busy  out  1  high whenever state != IDLE
- err_count  out  8  saturating count of rejected frames and timeouts

## Operation
- Reset value of every output, and of the result and frame registers, is 0. The FSM resets to IDLE.
- States: IDLE, DECODE, LOAD, WAIT_DONE, SEND.
- IDLE: on frame_valid, latch frame_in and go to DECODE. frame_valid in any other state drops the frame and increments err_count.
- DECODE: if command byte != trailer byte, increment err_count and return to IDLE with no response. Otherwise dispatch on the command:
  - "C": aes_key <= payload, then IDLE.
  - "D": aes_text_in <= payload, then IDLE.
  - "E": go to LOAD.
  - "A": tx_frame <= {"A", payload, "A"} (echo), then SEND.
  - "B": tx_frame <= {"B", result, "B"}, then SEND.
  - Any other byte: tx_frame <= {"N", payload, "N"}, then SEND.
- LOAD: aes_ld = 1 for exactly this cycle, clear the timeout counter, then WAIT_DONE.
- WAIT_DONE: on the first cycle aes_done = 1, result <= aes_text_out, tx_frame <= {"E", aes_text_out, "E"}, then SEND. If the counter reaches TIMEOUT_CYCLES-1 without aes_done: tx_frame <= {"T", 128'h0, "T"}, increment err_count, then SEND.
- SEND: wait for tx_ready. In the cycle tx_ready = 1, tx_send = 1 and the next state is IDLE. tx_frame holds its value until the next response.
- err_count saturates at 255. No wrap.
- aes_key and aes_text_in change only in DECODE, so they are stable across LOAD and WAIT_DONE.
- Reset mid-operation: aes_ld, tx_send and busy drop asynchronously. Any pending response is discarded.

## Timing
- Cycle 0: frame_valid. Cycle 1: DECODE. Cycle 2: "C"/"D" register visible; FSM is in IDLE.
- "A"/"B"/"N" with tx_ready held high: tx_send in cycle 2, IDLE in cycle 3.
- "E": aes_ld in cycle 2, WAIT_DONE from cycle 3. tx_send comes 1 cycle after the aes_done cycle, if tx_ready is high.
- Timeout: the "T" frame enters SEND exactly TIMEOUT_CYCLES cycles after WAIT_DONE entry.
- A frame arriving in the same cycle as the SEND→IDLE transition is dropped (busy is still 1) and counted.
- aes_done outside WAIT_DONE is ignored.

## Structure
- Shared package aes_cmd_pkg holds:
  - command byte constants CMD_TEST "A", CMD_READ "B", CMD_KEY "C", CMD_TEXT "D", CMD_ENC "E", RSP_NAK "N", RSP_TMO "T"
  - the state encoding
  - FRAME_BYTES and DBITS defaults
- One sub-module, cmd_watchdog: resettable cycle counter with clear and enable inputs and an expired output, parameterised by TIMEOUT_CYCLES.
- The rest (FSM, frame registers, error counter) lives in aes_cmd_sequencer.

## Test plan
- "C"+key 000102…0f+"C", then "D"+plaintext 00112233…eeff+"D", then "E"+16×00+"E", with a core model giving done after 12 cycles:
  - aes_ld pulses once with the loaded key and text
  - tx_frame = {"E", 69c4e0d86a7b0430d8cdb78070b4c55a, "E"}
  - a following "B" frame returns the same 128 bits
- "A"+"0123456789abcdef"+"A" with tx_ready = 1 → tx_send in cycle 2, tx_frame equals the input frame.
- "C"+payload+"D" (mismatched trailer) → no tx_send, aes_key unchanged, err_count 0→1.
- "E" frame with a core that never asserts done → tx_frame = {"T", 0, "T"} exactly 64 cycles after WAIT_DONE entry, err_count +1.
- Second frame_valid during WAIT_DONE → frame dropped, err_count +1, the original "E" response is still sent. After 300 bad frames err_count = 255.
- reset pulsed during SEND with tx_ready = 0 → state IDLE, tx_send never asserted, all outputs 0.

Source files
------------

// File: rtl/aes_cmd_pkg.sv
// Shared definitions for the AES command sequencer: frame geometry,
// command/response byte codes, FSM state encoding and a frame builder.
package aes_cmd_pkg;

  localparam int unsigned FRAME_BYTES = 18;
  localparam int unsigned DBITS       = 8;
  localparam int unsigned FRAME_W     = FRAME_BYTES * DBITS;
  localparam int unsigned PAYLOAD_W   = (FRAME_BYTES - 2) * DBITS;

  localparam logic [DBITS-1:0] CMD_TEST = "A";
  localparam logic [DBITS-1:0] CMD_READ = "B";
  localparam logic [DBITS-1:0] CMD_KEY  = "C";
  localparam logic [DBITS-1:0] CMD_TEXT = "D";
  localparam logic [DBITS-1:0] CMD_ENC  = "E";
  localparam logic [DBITS-1:0] RSP_NAK  = "N";
  localparam logic [DBITS-1:0] RSP_TMO  = "T";

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_SEND
  } state_e;

  // Response frames carry the same tag byte at both ends.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [DBITS-1:0]     tag,
                                                     input logic [PAYLOAD_W-1:0] body);
    return {tag, body, tag};
  endfunction

endpackage

// File: rtl/aes_cmd_sequencer_watchdog.sv
// cmd_watchdog: timeout counter for the sequencer's wait on the cipher core.
//   clk, reset  : system clock, async active-high reset
//   clear_i     : reload the counter to a full timeout window
//   enable_i    : consume one cycle of the window
//   expired_o   : window exhausted (last allowed cycle reached)
// Counts down from TIMEOUT_CYCLES-1 so expiry is a compare against zero;
// the counter parks at zero rather than wrapping.
module cmd_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LAST;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= LAST;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/aes_cmd_sequencer.sv
// aes_cmd_sequencer: decodes 18-byte UART command frames, drives the AES core
// key/text registers and start strobe, and builds 18-byte response frames.
//   clk, reset              : system clock, async active-high reset
//   frame_in / frame_valid  : received frame and its one-cycle strobe
//   tx_ready                : transmitter can accept a frame
//   aes_done / aes_text_out : core completion strobe and result
//   aes_key / aes_text_in   : key and plaintext registers to the core
//   aes_ld                  : one-cycle core start strobe
//   tx_frame / tx_send      : response frame and its transmit trigger
//   busy                    : FSM not idle
//   err_count               : saturating count of dropped/rejected frames and timeouts
//
// state        | meaning
// ST_IDLE      | waiting for a frame
// ST_DECODE    | check framing and dispatch latched command
// ST_LOAD      | pulse aes_ld, arm watchdog
// ST_WAIT_DONE | wait for aes_done or watchdog expiry
// ST_SEND      | hold response until tx_ready, then pulse tx_send
module aes_cmd_sequencer
  import aes_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FRAME_W-1:0]   frame_in,
  input  logic                 frame_valid,
  input  logic                 tx_ready,
  input  logic                 aes_done,
  input  logic [PAYLOAD_W-1:0] aes_text_out,
  output logic [PAYLOAD_W-1:0] aes_key,
  output logic [PAYLOAD_W-1:0] aes_text_in,
  output logic                 aes_ld,
  output logic [FRAME_W-1:0]   tx_frame,
  output logic                 tx_send,
  output logic                 busy,
  output logic [7:0]           err_count
);

  state_e                 state_q, state_d;
  logic [FRAME_W-1:0]     frame_q, frame_d;
  logic [PAYLOAD_W-1:0]   key_q, key_d;
  logic [PAYLOAD_W-1:0]   text_q, text_d;
  logic [PAYLOAD_W-1:0]   result_q, result_d;
  logic [FRAME_W-1:0]     tx_frame_q, tx_frame_d;
  logic [7:0]             err_q, err_d;
  logic [1:0]             err_inc;
  logic [8:0]             err_sum;
  logic                   wd_clear, wd_en, wd_expired;

  logic [DBITS-1:0]       cmd_byte, trl_byte;
  logic [PAYLOAD_W-1:0]   payload;

  assign cmd_byte = frame_q[FRAME_W-1 -: DBITS];
  assign trl_byte = frame_q[DBITS-1:0];
  assign payload  = frame_q[FRAME_W-DBITS-1:DBITS];

  cmd_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wd_clear),
    .enable_i  (wd_en),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    key_d      = key_q;
    text_d     = text_q;
    result_d   = result_q;
    tx_frame_d = tx_frame_q;
    err_inc    = 2'd0;
    wd_clear   = 1'b0;
    wd_en      = 1'b0;

    // A frame can be dropped in the same cycle as a decode error or timeout,
    // so up to two error events are summed per cycle.
    if (frame_valid && (state_q != ST_IDLE)) err_inc = 2'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_valid) begin
          frame_d = frame_in;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cmd_byte != trl_byte) begin
          err_inc = err_inc + 2'd1;
          state_d = ST_IDLE;
        end else begin
          unique case (cmd_byte)
            CMD_KEY: begin
              key_d   = payload;
              state_d = ST_IDLE;
            end
            CMD_TEXT: begin
              text_d  = payload;
              state_d = ST_IDLE;
            end
            CMD_ENC: state_d = ST_LOAD;
            CMD_TEST: begin
              tx_frame_d = build_frame(CMD_TEST, payload);
              state_d    = ST_SEND;
            end
            CMD_READ: begin
              tx_frame_d = build_frame(CMD_READ, result_q);
              state_d    = ST_SEND;
            end
            default: begin
              tx_frame_d = build_frame(RSP_NAK, payload);
              state_d    = ST_SEND;
            end
          endcase
        end
      end
      ST_LOAD: begin
        wd_clear = 1'b1;
        state_d  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        wd_en = 1'b1;
        if (aes_done) begin
          result_d   = aes_text_out;
          tx_frame_d = build_frame(CMD_ENC, aes_text_out);
          state_d    = ST_SEND;
        end else if (wd_expired) begin
          tx_frame_d = build_frame(RSP_TMO, '0);
          err_inc    = err_inc + 2'd1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    err_sum = {1'b0, err_q} + {7'b0, err_inc};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      key_q      <= '0;
      text_q     <= '0;
      result_q   <= '0;
      tx_frame_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      key_q      <= key_d;
      text_q     <= text_d;
      result_q   <= result_d;
      tx_frame_q <= tx_frame_d;
      err_q      <= err_d;
    end
  end

  // Strobes decode straight from the state register so reset kills them at once.
  assign aes_ld      = (state_q == ST_LOAD);
  assign tx_send     = (state_q == ST_SEND) && tx_ready;
  assign busy        = (state_q != ST_IDLE);
  assign aes_key     = key_q;
  assign aes_text_in = text_q;
  assign tx_frame    = tx_frame_q;
  assign err_count   = err_q;

endmodule
